// File: rtl/dac_stream_writer.sv
// Dual-channel DAC stream writer: buffers signed {A,B} sample pairs in a small FIFO
// and releases one pair per programmable rate tick as offset-binary DAC codes.
module dac_stream_writer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [13:0] MIDSCALE   = 14'd8191
) (
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic signed [13:0] i_data_A,
  input  logic signed [13:0] i_data_B,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic        [7:0]  i_divider,
  input  logic        [1:0]  i_shift,
  input  logic               i_clear,
  output logic        [13:0] o_DA,
  output logic        [13:0] o_DB,
  output logic               o_update,
  output logic               o_overflow,
  output logic               o_underrun
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Bit 14 flags a clamp; bits 13:0 carry the DAC code.
  function automatic logic [14:0] to_dac(input logic signed [13:0] x,
                                         input logic        [1:0]  sh);
    logic signed [13:0] s;
    logic signed [15:0] r;
    s = x >>> sh;
    r = 16'(s) + $signed({2'b00, MIDSCALE});
    if (r < 16'sd0)
      to_dac = {1'b1, 14'd0};
    else if (r > 16'sd16383)
      to_dac = {1'b1, 14'h3FFF};
    else
      to_dac = {1'b0, r[13:0]};
  endfunction

  logic signed [13:0] mem_a [FIFO_DEPTH];
  logic signed [13:0] mem_b [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic [7:0]         cnt;

  logic               tick, push, pop, empty;
  logic signed [13:0] head_a_p0, head_b_p0;
  logic [14:0]        conv_a_p0, conv_b_p0;

  logic [13:0]        da_p1, db_p1;
  logic               vld_p1, ovf_q, unr_q;

  assign empty     = (count == '0);
  assign o_ready   = (count != FULL_CNT);
  assign tick      = (cnt >= i_divider);
  assign push      = i_valid && o_ready;
  assign pop       = tick && !empty;

  // ---- stage p0: FIFO head, conversion with pop-time shift ----
  assign head_a_p0 = mem_a[rd_ptr];
  assign head_b_p0 = mem_b[rd_ptr];
  assign conv_a_p0 = to_dac(head_a_p0, i_shift);
  assign conv_b_p0 = to_dac(head_b_p0, i_shift);

  always_ff @(posedge i_clock) begin
    if (push) begin
      mem_a[wr_ptr] <= i_data_A;
      mem_b[wr_ptr] <= i_data_B;
    end
  end

  // ---- stage p1: registered DAC codes, update strobe and sticky flags ----
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      cnt    <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      da_p1  <= MIDSCALE;
      db_p1  <= MIDSCALE;
      vld_p1 <= 1'b0;
      ovf_q  <= 1'b0;
      unr_q  <= 1'b0;
    end else begin
      cnt <= tick ? 8'd0 : cnt + 8'd1;

      if (push && !pop)
        count <= count + CNT_ONE;
      else if (pop && !push)
        count <= count - CNT_ONE;

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      vld_p1 <= pop;
      if (pop) begin
        da_p1 <= conv_a_p0[13:0];
        db_p1 <= conv_b_p0[13:0];
      end

      // A set event in the same cycle as i_clear keeps the flag high.
      if (pop && (conv_a_p0[14] || conv_b_p0[14]))
        ovf_q <= 1'b1;
      else if (i_clear)
        ovf_q <= 1'b0;

      if (tick && empty)
        unr_q <= 1'b1;
      else if (i_clear)
        unr_q <= 1'b0;
    end
  end

  assign o_DA       = da_p1;
  assign o_DB       = db_p1;
  assign o_update   = vld_p1;
  assign o_overflow = ovf_q;
  assign o_underrun = unr_q;

endmodule

// File: tb/tb_dac_stream_writer.sv
// Scoreboard bench for dac_stream_writer: expected DAC codes are queued as pairs are
// issued; a negedge monitor checks each o_update against the queue head.
module tb_dac_stream_writer;

  logic               i_clock = 1'b0;
  logic               i_RESET = 1'b0;
  logic signed [13:0] i_data_A = '0;
  logic signed [13:0] i_data_B = '0;
  logic               i_valid = 1'b0;
  logic               o_ready;
  logic        [7:0]  i_divider = 8'd200;
  logic        [1:0]  i_shift = 2'd0;
  logic               i_clear = 1'b0;
  logic        [13:0] o_DA, o_DB;
  logic               o_update, o_overflow, o_underrun;

  int errors = 0;
  int checks = 0;
  logic [27:0] exp_q [$];

  dac_stream_writer #(.FIFO_DEPTH(4), .MIDSCALE(14'd8191)) dut (
    .i_clock(i_clock), .i_RESET(i_RESET), .i_data_A(i_data_A), .i_data_B(i_data_B),
    .i_valid(i_valid), .o_ready(o_ready), .i_divider(i_divider), .i_shift(i_shift),
    .i_clear(i_clear), .o_DA(o_DA), .o_DB(o_DB), .o_update(o_update),
    .o_overflow(o_overflow), .o_underrun(o_underrun)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every update must match the oldest outstanding expectation.
  always @(negedge i_clock) begin
    if (i_RESET && o_update) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_update: got DA=%0d DB=%0d expected no update", o_DA, o_DB);
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        chk("update_DA", int'(o_DA), int'(e[27:14]));
        chk("update_DB", int'(o_DB), int'(e[13:0]));
      end
    end
  end

  // All tasks start and end #1 after a rising edge.
  task automatic push(input int a, input int b, input int ea, input int eb, input bit track);
    bit ok;
    int n;
    n = 0;
    i_data_A = 14'(a);
    i_data_B = 14'(b);
    i_valid  = 1'b1;
    if (track) exp_q.push_back({14'(ea), 14'(eb)});
    forever begin
      @(negedge i_clock);
      ok = o_ready;
      @(posedge i_clock);
      if (ok) break;
      n++;
      if (n > 200) begin
        chk("push_accept_timeout", 0, 1);
        break;
      end
    end
    #1 i_valid = 1'b0;
  endtask

  task automatic tick_now();
    i_divider = 8'd0;
    @(posedge i_clock);
    #1 i_divider = 8'd200;
  endtask

  task automatic clear_flags();
    i_clear = 1'b1;
    @(posedge i_clock);
    #1 i_clear = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge i_clock);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(posedge i_clock);
    #1;
  endtask

  initial begin
    int k, n, first_c, second_c, upd_cnt;
    bit full_checked, rise_checked, accept;

    // Reset state
    repeat (3) @(negedge i_clock);
    chk("rst_DA", o_DA, 8191);
    chk("rst_DB", o_DB, 8191);
    chk("rst_update", o_update, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_underrun", o_underrun, 0);
    chk("rst_ready", o_ready, 1);

    // Single pair, divider 3, then underrun on the following tick
    i_divider = 8'd3;
    i_RESET = 1'b1;
    @(posedge i_clock);
    #1;
    push(100, -100, 8291, 8091, 1);
    wait_drain();
    n = 0;
    while (!o_underrun && n < 20) begin
      @(negedge i_clock);
      n++;
    end
    chk("underrun_after_pop", o_underrun, 1);
    chk("no_overflow_basic", o_overflow, 0);

    i_divider = 8'd200;
    clear_flags();
    @(negedge i_clock);
    chk("clear_underrun", o_underrun, 0);
    @(posedge i_clock);
    #1;

    // Clamp and shift behaviour
    push(-8192, 8191, 0, 16382, 1);
    tick_now();
    wait_drain();
    chk("overflow_set", o_overflow, 1);
    clear_flags();
    @(negedge i_clock);
    chk("overflow_cleared", o_overflow, 0);
    @(posedge i_clock);
    #1;
    i_shift = 2'd2;
    push(-8192, 8191, 6143, 10238, 1);
    tick_now();
    wait_drain();
    chk("no_new_overflow_shift2", o_overflow, 0);
    i_shift = 2'd0;
    push(1000, -1000, 8691, 7691, 1);
    i_shift = 2'd1;
    tick_now();
    wait_drain();
    i_shift = 2'd0;

    // Push and tick in the same cycle into an empty FIFO
    clear_flags();
    @(negedge i_clock);
    chk("pre_sim_underrun", o_underrun, 0);
    @(posedge i_clock);
    #1;
    i_data_A = -14'sd1;
    i_data_B = 14'sd1;
    exp_q.push_back({14'd8190, 14'd8192});
    i_valid = 1'b1;
    i_divider = 8'd0;
    @(posedge i_clock);
    #1 i_valid = 1'b0;
    @(posedge i_clock);
    #1 i_divider = 8'd200;
    chk("sim_push_tick_underrun", o_underrun, 1);
    wait_drain();
    i_clear = 1'b1;
    i_divider = 8'd0;
    @(posedge i_clock);
    #1 i_clear = 1'b0;
    i_divider = 8'd200;
    @(negedge i_clock);
    chk("clear_vs_set_underrun", o_underrun, 1);
    @(posedge i_clock);
    #1;
    clear_flags();
    @(negedge i_clock);
    chk("clear_after_set", o_underrun, 0);
    @(posedge i_clock);
    #1;

    // Backpressure: valid held, divider 9, 20 pairs through a 4-deep FIFO
    tick_now();
    i_divider = 8'd9;
    k = 0;
    full_checked = 0;
    rise_checked = 0;
    i_data_A = 14'(k * 10);
    i_data_B = 14'(-k * 10);
    i_valid = 1'b1;
    for (int cyc = 0; cyc < 1000 && k < 20; cyc++) begin
      @(negedge i_clock);
      if (k == 4 && !full_checked) begin
        chk("ready_low_when_full", o_ready, 0);
        full_checked = 1;
      end
      if (o_update && k >= 4 && !rise_checked) begin
        chk("ready_after_pop", o_ready, 1);
        rise_checked = 1;
      end
      accept = o_ready;
      @(posedge i_clock);
      if (accept) begin
        exp_q.push_back({14'(8191 + k * 10), 14'(8191 - k * 10)});
        k++;
      end
      #1;
      i_data_A = 14'(k * 10);
      i_data_B = 14'(-k * 10);
      if (k == 20) i_valid = 1'b0;
    end
    i_valid = 1'b0;
    chk("pairs_accepted", k, 20);
    wait_drain();
    i_divider = 8'd200;

    // Divider lowered 200 -> 5 while cnt = 50
    tick_now();
    push(7, -7, 8198, 8184, 1);
    push(8, -8, 8199, 8183, 1);
    repeat (48) @(posedge i_clock);
    #1 i_divider = 8'd5;
    first_c = 0;
    second_c = 0;
    upd_cnt = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge i_clock);
      if (o_update) begin
        upd_cnt++;
        if (upd_cnt == 1) first_c = c;
        if (upd_cnt == 2) second_c = c;
      end
    end
    chk("div_drop_first_tick", first_c, 2);
    chk("div_drop_period", second_c, 8);
    chk("div_drop_updates", upd_cnt, 2);
    @(posedge i_clock);
    #1 i_divider = 8'd200;

    // Reset with three pairs buffered: all discarded
    tick_now();
    push(1, 1, 0, 0, 0);
    push(2, 2, 0, 0, 0);
    push(3, 3, 0, 0, 0);
    @(negedge i_clock);
    i_RESET = 1'b0;
    @(negedge i_clock);
    chk("mid_rst_DA", o_DA, 8191);
    chk("mid_rst_DB", o_DB, 8191);
    chk("mid_rst_ready", o_ready, 1);
    chk("mid_rst_underrun", o_underrun, 0);
    i_divider = 8'd3;
    i_RESET = 1'b1;
    repeat (3) @(negedge i_clock);
    chk("post_rst_no_tick_yet", o_underrun, 0);
    @(negedge i_clock);
    chk("post_rst_first_tick", o_underrun, 1);
    upd_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clock);
      if (o_update) upd_cnt++;
    end
    chk("post_rst_no_update", upd_cnt, 0);
    @(posedge i_clock);
    #1;
    push(5, -5, 8196, 8186, 1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dac_stream_writer.md
DAC_STREAM_WRITER -- requirements
Module: dac_stream_writer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving sample-pair buffer entries (power of two, 2..16).
REQ-002 The block SHALL have parameter MIDSCALE, default 14'd8191, giving the DAC code for signed zero.
REQ-003 i_clock  input  1  sole clock (100 MHz system clock); all logic on rising edge.
REQ-004 i_RESET  input  1  reset, asynchronous, active-low.
REQ-005 i_data_A  input  14  signed two's-complement sample for channel A.
REQ-006 i_data_B  input  14  signed two's-complement sample for channel B.
REQ-007 i_valid  input  1  producer offers the {A,B} pair this cycle.
REQ-008 o_ready  output  1  block can accept a pair this cycle.
REQ-009 i_divider  input  8  DAC update period minus one, in i_clock cycles.
REQ-010 i_shift  input  2  arithmetic right shift (0..3) applied to both samples before offsetting.
REQ-011 i_clear  input  1  synchronous clear of sticky flags.
REQ-012 o_DA  output  14  offset-binary DAC code, channel A (registered).
REQ-013 o_DB  output  14  offset-binary DAC code, channel B (registered).
REQ-014 o_update  output  1  one-cycle pulse in the cycle o_DA/o_DB take a new value.
REQ-015 o_overflow  output  1  sticky: a conversion was clamped.
REQ-016 o_underrun  output  1  sticky: an update tick found the FIFO empty.

Function
REQ-017 Handshake: a pair SHALL be pushed on a rising edge where i_valid=1 and o_ready=1; o_ready SHALL equal "FIFO not full" from the registered count, with no combinational path from i_valid.
REQ-018 i_valid while o_ready=0 SHALL be dropped and leave FIFO contents, pointers and count unchanged.
REQ-019 Rate counter: cnt SHALL count 0..i_divider; tick=1 when cnt>=i_divider, and cnt then returns to 0 next edge; i_divider=0 gives a tick every cycle.
REQ-020 Lowering i_divider below the current cnt SHALL produce a tick on the next cycle (>= compare, no wrap through 255).
REQ-021 Tick with FIFO non-empty (registered count>0): pop head; on the same edge o_DA/o_DB SHALL load the converted head pair and o_update SHALL be 1 for the following cycle only.
REQ-022 Tick with FIFO empty: o_DA/o_DB SHALL hold, o_update SHALL stay 0, o_underrun SHALL set.
REQ-023 Simultaneous push and pop SHALL be allowed, with count unchanged; a push into an empty FIFO is not visible to a tick in the same cycle (that tick is an underrun).
REQ-024 Latency: a pair pushed at edge t SHALL reach o_DA/o_DB no earlier than edge t+1, on the first tick after it reaches the FIFO head.
REQ-025 Conversion per channel: s = sample >>> i_shift (sign-extended); r = s + MIDSCALE in 15-bit signed arithmetic; clamp to 0..16383.
REQ-026 Any clamp on either channel during a pop SHALL set o_overflow; with default MIDSCALE only input -8192 at shift 0 clamps (to 0).
REQ-027 i_shift SHALL be sampled at pop time, not at push time.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-029 i_clear=1 SHALL clear o_overflow/o_underrun next edge; a set event in the same cycle SHALL win (flag stays 1).

Reset
REQ-030 While i_RESET=0: FIFO empty, pointers and cnt 0, o_DA=o_DB=MIDSCALE, o_update=0, o_overflow=0, o_underrun=0, o_ready=1.
REQ-031 Reset asserted mid-stream SHALL discard all buffered pairs immediately; after release, the first tick SHALL occur i_divider+1 cycles after the first active edge.

Verification
REQ-032 i_divider=3, push A=100,B=-100 once -> o_DA=8291, o_DB=8091 at the first tick, o_update high exactly one cycle, then underrun set on the following tick.
REQ-033 i_valid held 1, i_divider=9, FIFO_DEPTH=4 -> o_ready falls after 4 pushes, rises one cycle after each pop, no pair lost or duplicated across 20 pops.
REQ-034 A=-8192,B=8191, shift 0 -> o_DA=0, o_DB=16382, overflow=1; the same pair at shift 2 -> o_DA=6143, o_DB=10238, no new overflow after i_clear.
REQ-035 FIFO empty, push and tick in the same cycle -> underrun=1 and the pair output on the next tick; i_clear together with a new underrun -> flag stays 1.
REQ-036 Reset pulsed with 3 pairs buffered -> outputs 8191/8191, o_ready=1, no o_update until a new pair is pushed.
REQ-037 i_divider changed 200->5 while cnt=50 -> tick next cycle, then a period of 6 cycles.
